// File: rtl/note_judge_scheduler.sv
// Per-lane judgment buffer that serializes hit/miss judgments into one-hot round-robin pulses
// and sequences song start/clear/drain. Optional saturating drop counter: SCHED_DROP_CNT_EN.
module note_judge_scheduler #(
    parameter int unsigned LANES = 8,
    parameter int unsigned GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             song_end,
    input  logic [LANES-1:0] hit_valid,
    input  logic [LANES-1:0] hit_good,
    output logic [LANES-1:0] note_action,
    output logic [LANES-1:0] note_success,
    output logic             score_clr,
    output logic [1:0]       state,
    output logic [LANES-1:0] pending,
    output logic [7:0]       dropped_cnt,
    output logic             done
);

    localparam int unsigned PTR_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned GAP_W = 4;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_PLAY  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [LANES-1:0]   pending_q, pending_d;
    logic [LANES-1:0]   good_q, good_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [LANES-1:0]   note_action_q, note_action_d;
    logic [LANES-1:0]   note_success_q, note_success_d;
    logic               score_clr_q, score_clr_d;
    logic               done_q, done_d;

    logic [LANES-1:0]   grant_c;
    logic [PTR_W-1:0]   grant_idx_c;
    logic               grant_vld_c;
    logic [PTR_W-1:0]   scan_idx_c;
    logic [LANES-1:0]   accept_c;

    // Round-robin pick: first pending lane at or above rr_ptr, wrapping.
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        grant_vld_c = 1'b0;
        scan_idx_c  = '0;
        if ((state_q == ST_PLAY || state_q == ST_DRAIN) && gap_cnt_q == '0) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                scan_idx_c = PTR_W'((32'(rr_ptr_q) + k) % LANES);
                if (!grant_vld_c && pending_q[scan_idx_c]) begin
                    grant_vld_c          = 1'b1;
                    grant_idx_c          = scan_idx_c;
                    grant_c[scan_idx_c]  = 1'b1;
                end
            end
        end
    end

    // Next-state, capture and pulse generation.
    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        good_d         = good_q;
        rr_ptr_d       = rr_ptr_q;
        gap_cnt_d      = gap_cnt_q;
        note_action_d  = '0;
        note_success_d = '0;
        score_clr_d    = 1'b0;
        done_d         = 1'b0;
        accept_c       = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                score_clr_d = 1'b1;
                pending_d   = '0;
                rr_ptr_d    = '0;
                gap_cnt_d   = '0;
                state_d     = ST_PLAY;
            end
            ST_PLAY, ST_DRAIN: begin
                if (grant_vld_c) begin
                    note_action_d  = grant_c;
                    note_success_d = grant_c & good_q;
                    pending_d      = pending_q & ~grant_c;
                    rr_ptr_d       = (32'(grant_idx_c) + 1 == LANES) ? '0
                                     : PTR_W'(32'(grant_idx_c) + 1);
                    gap_cnt_d      = GAP_W'(GAP);
                end else if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end

                if (state_q == ST_PLAY) begin
                    // A lane granted this cycle is free again for a new judgment.
                    accept_c  = hit_valid & (~pending_q | grant_c);
                    pending_d = pending_d | accept_c;
                    good_d    = (good_q & ~accept_c) | (hit_good & accept_c);
                    if (song_end) begin
                        state_d = ST_DRAIN;
                    end
                end else if (pending_q == '0 && gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            pending_q      <= '0;
            good_q         <= '0;
            rr_ptr_q       <= '0;
            gap_cnt_q      <= '0;
            note_action_q  <= '0;
            note_success_q <= '0;
            score_clr_q    <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            good_q         <= good_d;
            rr_ptr_q       <= rr_ptr_d;
            gap_cnt_q      <= gap_cnt_d;
            note_action_q  <= note_action_d;
            note_success_q <= note_success_d;
            score_clr_q    <= score_clr_d;
            done_q         <= done_d;
        end
    end

`ifdef SCHED_DROP_CNT_EN
    logic [LANES-1:0] drop_vec_c;
    int unsigned      drop_sum_c;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of judgments rejected because their lane was still pending.
    always_comb begin
        drop_vec_c = '0;
        if (state_q == ST_PLAY) begin
            drop_vec_c = hit_valid & pending_q & ~grant_c;
        end
        drop_sum_c = 32'(drop_cnt_q) + 32'($countones(drop_vec_c));
        if (state_q == ST_CLEAR) begin
            drop_cnt_d = '0;
        end else if (drop_sum_c > 32'(255)) begin
            drop_cnt_d = CNT_W'(255);
        end else begin
            drop_cnt_d = CNT_W'(drop_sum_c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign dropped_cnt = drop_cnt_q;
`else
    assign dropped_cnt = '0;
`endif

    assign note_action  = note_action_q;
    assign note_success = note_success_q;
    assign score_clr    = score_clr_q;
    assign done         = done_q;
    assign state        = state_q;
    assign pending      = pending_q;

endmodule

// File: tb/tb_note_judge_scheduler.sv
// Bench for note_judge_scheduler: directed scenarios plus random traffic, all cycles
// compared against a behavioural lane-array model.
module tb_note_judge_scheduler;

    localparam int LANES = 8;
    localparam int GAP   = 1;
`ifdef SCHED_DROP_CNT_EN
    localparam int DROP_EN = 1;
`else
    localparam int DROP_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst, start, song_end;
    logic [7:0] hit_valid, hit_good;
    logic [7:0] note_action, note_success, pending, dropped_cnt;
    logic [1:0] state;
    logic       score_clr, done;

    note_judge_scheduler #(.LANES(LANES), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .start(start), .song_end(song_end),
        .hit_valid(hit_valid), .hit_good(hit_good),
        .note_action(note_action), .note_success(note_success),
        .score_clr(score_clr), .state(state), .pending(pending),
        .dropped_cnt(dropped_cnt), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Model: song phase, per-lane buffer arrays, pointer and gap as plain integers.
    int         m_phase;
    bit         m_pend [LANES];
    bit         m_good [LANES];
    int         m_rr, m_gap, m_drop;
    logic [7:0] m_act, m_succ;
    bit         m_clr, m_done;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit bit_of(input logic [7:0] v, input int i);
        return |((v >> i) & 8'h01);
    endfunction

    function automatic logic [7:0] pend_vec();
        logic [7:0] v = '0;
        for (int i = 0; i < LANES; i++) if (m_pend[i]) v = v | (8'h01 << i);
        return v;
    endfunction

    task automatic model_step();
        int  g;
        int  gap0;
        bit  anyp;
        m_act = '0; m_succ = '0; m_clr = 0; m_done = 0;
        if (rst) begin
            m_phase = 0; m_rr = 0; m_gap = 0; m_drop = 0;
            for (int i = 0; i < LANES; i++) begin m_pend[i] = 0; m_good[i] = 0; end
        end else begin
            g = -1; gap0 = m_gap; anyp = 0;
            for (int i = 0; i < LANES; i++) anyp |= m_pend[i];
            if ((m_phase == 2 || m_phase == 3) && m_gap == 0)
                for (int k = 0; k < LANES; k++)
                    if (g < 0 && m_pend[(m_rr + k) % LANES]) g = (m_rr + k) % LANES;
            if (m_phase == 0) begin
                if (start) m_phase = 1;
            end else if (m_phase == 1) begin
                m_clr = 1; m_rr = 0; m_gap = 0; m_drop = 0; m_phase = 2;
                for (int i = 0; i < LANES; i++) m_pend[i] = 0;
            end else begin
                if (g >= 0) begin
                    m_act  = 8'h01 << g;
                    m_succ = m_good[g] ? m_act : 8'h00;
                    m_pend[g] = 0;
                    m_rr  = (g + 1) % LANES;
                    m_gap = GAP;
                end else if (m_gap > 0) begin
                    m_gap--;
                end
                if (m_phase == 2) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (bit_of(hit_valid, i)) begin
                            if (m_pend[i]) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                            else begin m_pend[i] = 1; m_good[i] = bit_of(hit_good, i); end
                        end
                    end
                    if (song_end) m_phase = 3;
                end else if (!anyp && gap0 == 0) begin
                    m_phase = 0; m_done = 1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        check_eq("action",  note_action,  m_act);
        check_eq("success", note_success, m_succ);
        check_eq("clr",     score_clr,    m_clr);
        check_eq("done",    done,         m_done);
        check_eq("state",   state,        m_phase);
        check_eq("pending", pending,      pend_vec());
        check_eq("dropped", dropped_cnt,  DROP_EN ? m_drop : 0);
    endtask

    task automatic drive(input logic s, input logic e, input logic [7:0] hv, input logic [7:0] hg);
        start = s; song_end = e; hit_valid = hv; hit_good = hg;
    endtask

    task automatic drain_until_done(input string tag, output int pulses);
        bit seen = 0;
        pulses = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            if (note_action != 0) pulses++;
            if (done) seen = 1;
        end
        check_eq({tag, "_done_seen"}, 32'(seen), 1);
    endtask

    initial begin
        int pulses;
        rst = 1'b1;
        drive(0, 0, 8'h00, 8'h00);
        tick(); tick();
        check_eq("rst_state", state, 0);
        check_eq("rst_action", note_action, 0);
        rst = 1'b0;
        tick();

        // Song start: one clear pulse, then PLAY.
        drive(1, 0, 8'h00, 8'h00);
        tick();
        drive(0, 0, 8'h00, 8'h00);
        tick();
        check_eq("start_clr", score_clr, 1);
        tick();
        check_eq("start_clr_once", score_clr, 0);
        check_eq("start_play", state, 2);

        // All lanes at once: lanes 0..7 in order, one pulse every GAP+1 cycles.
        drive(0, 0, 8'hFF, 8'h0F);
        tick();
        drive(0, 0, 8'h00, 8'h00);
        for (int j = 0; j < 16; j++) begin
            tick();
            if (j % 2 == 0) begin
                check_eq("rr_action", note_action, 8'h01 << (j / 2));
                check_eq("rr_success", note_success, (j / 2 < 4) ? (8'h01 << (j / 2)) : 8'h00);
            end else begin
                check_eq("rr_gap", note_action, 0);
            end
        end

        // Single lane latency.
        drive(0, 0, 8'h08, 8'h08);
        tick();
        check_eq("lat_pending", pending, 8'h08);
        drive(0, 0, 8'h00, 8'h00);
        tick();
        check_eq("lat_action", note_action, 8'h08);
        check_eq("lat_success", note_success, 8'h08);
        check_eq("lat_pending_clr", pending, 0);
        tick();
        check_eq("lat_single", note_action, 0);

        // Lane 5 blocked by the gap after lane 4, then hit again: drop, first result kept.
        drive(0, 0, 8'h30, 8'h20);
        tick();
        drive(0, 0, 8'h00, 8'h00);
        tick();
        check_eq("drop_first", note_action, 8'h10);
        drive(0, 0, 8'h20, 8'h00);
        tick();
        check_eq("drop_cnt", dropped_cnt, DROP_EN ? 1 : 0);
        drive(0, 0, 8'h00, 8'h00);
        tick();
        check_eq("drop_action", note_action, 8'h20);
        check_eq("drop_success", note_success, 8'h20);
        tick();

        // Song end with three pending, hits during DRAIN ignored.
        drive(0, 1, 8'h07, 8'h05);
        tick();
        check_eq("drain_state", state, 3);
        drive(0, 0, 8'hFF, 8'hFF);
        drain_until_done("drain", pulses);
        check_eq("drain_pulses", pulses, 3);
        check_eq("drain_dropped", dropped_cnt, DROP_EN ? 1 : 0);
        check_eq("drain_idle", state, 0);
        drive(0, 0, 8'h00, 8'h00);
        tick();
        check_eq("done_once", done, 0);

        // Reset in the middle of DRAIN.
        drive(1, 0, 8'h00, 8'h00);
        tick();
        drive(0, 0, 8'h00, 8'h00);
        tick(); tick();
        drive(0, 1, 8'h30, 8'h10);
        tick();
        check_eq("mid_pending", pending, 8'h30);
        drive(0, 0, 8'h00, 8'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_pending_rst", pending, 0);
        check_eq("mid_state_rst", state, 0);
        for (int j = 0; j < 4; j++) begin
            tick();
            check_eq("mid_no_action", note_action, 0);
        end

        // Saturation of the drop counter.
        drive(1, 0, 8'h00, 8'h00);
        tick();
        drive(0, 0, 8'h00, 8'h00);
        tick(); tick();
        drive(0, 0, 8'hFF, 8'hA5);
        for (int j = 0; j < 60; j++) tick();
        check_eq("sat_cnt", dropped_cnt, DROP_EN ? 255 : 0);
        drive(0, 1, 8'h00, 8'h00);
        tick();
        drive(0, 0, 8'h00, 8'h00);
        drain_until_done("sat_drain", pulses);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
                  8'($urandom) & 8'($urandom), 8'($urandom));
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
